// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative write-back cache.
// Holds the FSM encoding, word-select constants and width helpers.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPARE,
      ST_WRITEBACK,
      ST_REFILL
   } state_t;

   localparam int WORD_BITS  = 32;
   localparam int WORD_BYTES = 4;
   localparam int WORD_OFF   = 2;   // byte-address bits below the word select
   localparam int WORD_SH    = 5;   // log2(WORD_BITS): word index to bit offset

   // Width of a way index / age counter; a 1-way cache still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int words_per_line(input int line_size);
      return line_size / WORD_BYTES;
   endfunction

endpackage

// File: rtl/cache_lru.sv
// Age-based LRU for one set: promotes the hit way to MRU and picks the victim
// (lowest-index invalid way, otherwise the oldest way).
module cache_lru
   import cache_pkg::*;
#(
   parameter int NUM_WAYS = 2,
   parameter int AGE_W    = clog2_min1(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:0][AGE_W-1:0] ages,
   input  logic [NUM_WAYS-1:0]            valid,
   input  logic [AGE_W-1:0]               hit_way,
   output logic [NUM_WAYS-1:0][AGE_W-1:0] new_ages,
   output logic [AGE_W-1:0]               victim
);

   logic found;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      new_ages = ages;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (ages[w] < ages[hit_way]) new_ages[w] = ages[w] + AGE_W'(1);
      end
      new_ages[hit_way] = '0;
   end

   always_comb begin
      victim = '0;
      found  = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!found && !valid[w]) begin
            victim = AGE_W'(w);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (ages[w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
         end
      end
   end

endmodule

// File: rtl/assoc_wb_cache.sv
// N-way set-associative, write-back, write-allocate data cache with an
// exposed line-granular memory port; one outstanding CPU access at a time.
module assoc_wb_cache
   import cache_pkg::*;
#(
   parameter int LINE_SIZE = 16,
   parameter int NUM_SETS  = 16,
   parameter int NUM_WAYS  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   is_input_valid,
   input  logic [31:0]            addr,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            din,
   output logic                   is_ready,
   output logic                   is_output_valid,
   output logic [31:0]            dout,
   output logic                   is_hit,
   output logic                   m_is_input_valid,
   input  logic                   m_ready,
   output logic [31:0]            m_addr,
   output logic                   m_read,
   output logic                   m_write,
   output logic [LINE_SIZE*8-1:0] m_din,
   input  logic                   m_is_output_valid,
   input  logic [LINE_SIZE*8-1:0] m_dout
);

   localparam int OFF_SIZE  = $clog2(LINE_SIZE);
   localparam int IDX_SIZE  = $clog2(NUM_SETS);
   localparam int TAG_SIZE  = 32 - IDX_SIZE - OFF_SIZE;
   localparam int LINE_BITS = LINE_SIZE * 8;
   localparam int WSEL_SIZE = OFF_SIZE - WORD_OFF;
   localparam int WAY_W     = clog2_min1(NUM_WAYS);

   state_t state, next_state;

   logic [TAG_SIZE-1:0]  req_tag;
   logic [IDX_SIZE-1:0]  req_idx;
   logic [WSEL_SIZE-1:0] req_word;
   logic [31:0]          req_din;
   logic                 req_write;
   logic                 miss_flag;
   logic                 read_sent;
   logic [WAY_W-1:0]     victim_way;

   logic [NUM_WAYS-1:0]             valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0]             dirty_q [NUM_SETS];
   logic [NUM_WAYS-1:0][WAY_W-1:0]  age_q   [NUM_SETS];
   logic [TAG_SIZE-1:0]             tag_q   [NUM_SETS][NUM_WAYS];
   logic [LINE_BITS-1:0]            data_q  [NUM_SETS][NUM_WAYS];

   logic                            hit;
   logic [WAY_W-1:0]                hit_way;
   logic [NUM_WAYS-1:0][WAY_W-1:0]  lru_ages;
   logic [WAY_W-1:0]                lru_victim;
   logic [LINE_BITS-1:0]            hit_line;
   logic                            accept, store_hit, install, victim_dirty;
   logic                            ignored_unused;

   // Word alignment bits and the load strobe carry no information the FSM needs.
   assign ignored_unused = ^{addr[WORD_OFF-1:0], mem_read};

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   cache_lru #(.NUM_WAYS(NUM_WAYS), .AGE_W(WAY_W)) u_lru (
      .ages     (age_q[req_idx]),
      .valid    (valid_q[req_idx]),
      .hit_way  (hit_way),
      .new_ages (lru_ages),
      .victim   (lru_victim)
   );

   assign hit_line     = data_q[req_idx][hit_way];
   assign victim_dirty = valid_q[req_idx][lru_victim] && dirty_q[req_idx][lru_victim];
   assign accept       = (state == ST_IDLE) && is_input_valid && !reset;
   assign store_hit    = (state == ST_COMPARE) && hit && req_write && !reset;
   assign install      = (state == ST_REFILL) && read_sent && m_is_output_valid && !reset;

   always_comb begin
      next_state       = state;
      is_ready         = 1'b0;
      is_output_valid  = 1'b0;
      dout             = '0;
      is_hit           = 1'b0;
      m_is_input_valid = 1'b0;
      m_read           = 1'b0;
      m_write          = 1'b0;
      m_addr           = '0;
      m_din            = '0;
      if (!reset) begin
         case (state)
            ST_IDLE: begin
               is_ready = 1'b1;
               if (is_input_valid) next_state = ST_COMPARE;
            end
            ST_COMPARE: begin
               if (hit) begin
                  is_output_valid = 1'b1;
                  is_hit          = !miss_flag;
                  dout            = hit_line[{req_word, {WORD_SH{1'b0}}} +: WORD_BITS];
                  next_state      = ST_IDLE;
               end else begin
                  next_state = victim_dirty ? ST_WRITEBACK : ST_REFILL;
               end
            end
            ST_WRITEBACK: begin
               m_is_input_valid = 1'b1;
               m_write          = 1'b1;
               m_addr           = {tag_q[req_idx][victim_way], req_idx, {OFF_SIZE{1'b0}}};
               m_din            = data_q[req_idx][victim_way];
               if (m_ready) next_state = ST_REFILL;
            end
            ST_REFILL: begin
               if (!read_sent) begin
                  m_is_input_valid = 1'b1;
                  m_read           = 1'b1;
                  m_addr           = {req_tag, req_idx, {OFF_SIZE{1'b0}}};
               end else if (m_is_output_valid) begin
                  next_state = ST_COMPARE;
               end
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         miss_flag  <= 1'b0;
         read_sent  <= 1'b0;
         victim_way <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
         end
      end else begin
         state <= next_state;
         if (accept) miss_flag <= 1'b0;
         if ((state == ST_COMPARE) && hit) age_q[req_idx] <= lru_ages;
         if (store_hit) dirty_q[req_idx][hit_way] <= 1'b1;
         if ((state == ST_COMPARE) && !hit) begin
            victim_way <= lru_victim;
            read_sent  <= 1'b0;
         end
         if ((state == ST_REFILL) && !read_sent && m_ready) read_sent <= 1'b1;
         if (install) begin
            valid_q[req_idx][victim_way] <= 1'b1;
            dirty_q[req_idx][victim_way] <= 1'b0;
            miss_flag                    <= 1'b1;
         end
      end
   end

   // NOTE: tags, line data and the request latch have no reset; a line is only
   // ever read behind its valid bit, so clearing valid_q is sufficient.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_tag   <= addr[31 -: TAG_SIZE];
         req_idx   <= addr[OFF_SIZE +: IDX_SIZE];
         req_word  <= addr[OFF_SIZE-1:WORD_OFF];
         req_din   <= din;
         req_write <= mem_write;
      end
      if (store_hit) data_q[req_idx][hit_way][{req_word, {WORD_SH{1'b0}}} +: WORD_BITS] <= req_din;
      if (install) begin
         tag_q[req_idx][victim_way]  <= req_tag;
         data_q[req_idx][victim_way] <= m_dout;
      end
   end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache: cold/hit loads, store hit, LRU eviction,
// dirty writeback ordering, memory stall and reset during refill.
module tb_assoc_wb_cache;

   localparam int LINE_BITS = 128;
   localparam int MEM_LAT   = 5;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 is_input_valid;
   logic [31:0]          addr;
   logic                 mem_read;
   logic                 mem_write;
   logic [31:0]          din;
   logic                 is_ready;
   logic                 is_output_valid;
   logic [31:0]          dout;
   logic                 is_hit;
   logic                 m_is_input_valid;
   logic                 m_ready;
   logic [31:0]          m_addr;
   logic                 m_read;
   logic                 m_write;
   logic [LINE_BITS-1:0] m_din;
   logic                 m_is_output_valid;
   logic [LINE_BITS-1:0] m_dout;

   assoc_wb_cache dut (
      .clk               (clk),
      .reset             (reset),
      .is_input_valid    (is_input_valid),
      .addr              (addr),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .din               (din),
      .is_ready          (is_ready),
      .is_output_valid   (is_output_valid),
      .dout              (dout),
      .is_hit            (is_hit),
      .m_is_input_valid  (m_is_input_valid),
      .m_ready           (m_ready),
      .m_addr            (m_addr),
      .m_read            (m_read),
      .m_write           (m_write),
      .m_din             (m_din),
      .m_is_output_valid (m_is_output_valid),
      .m_dout            (m_dout)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;
   int n_checks = 0;

   // Memory model state
   logic [LINE_BITS-1:0] mem [256];
   int                   stall_cycles = 0;
   int                   seq = 0;
   int                   n_mwrite = 0;
   int                   n_mread = 0;
   int                   last_wr_seq = 0;
   int                   last_rd_seq = 0;
   logic [31:0]          last_wr_addr = '0;
   logic [31:0]          last_rd_addr = '0;
   logic [LINE_BITS-1:0] last_wr_din = '0;
   logic                 is_rd;
   int                   m_busy = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) if (m_is_input_valid) m_busy++;

   // Line memory: word at byte address a holds 0xA500_0000 | a, except 0x104.
   initial begin
      m_ready = 1'b0;
      m_is_output_valid = 1'b0;
      m_dout = '0;
      for (int i = 0; i < 256; i++)
         for (int k = 0; k < 4; k++) mem[i][k*32 +: 32] = 32'hA500_0000 | 32'(i*16 + k*4);
      mem[16][63:32] = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         if (m_is_input_valid) begin
            repeat (stall_cycles) @(negedge clk);
            m_ready = 1'b1;
            seq++;
            is_rd = m_read;
            if (m_write) begin
               n_mwrite++;
               last_wr_addr = m_addr;
               last_wr_din  = m_din;
               last_wr_seq  = seq;
               mem[m_addr[11:4]] = m_din;
            end else begin
               n_mread++;
               last_rd_addr = m_addr;
               last_rd_seq  = seq;
            end
            @(negedge clk);
            m_ready = 1'b0;
            if (is_rd) begin
               repeat (MEM_LAT - 1) @(negedge clk);
               m_dout = mem[last_rd_addr[11:4]];
               m_is_output_valid = 1'b1;
               @(negedge clk);
               m_is_output_valid = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
      int guard = 0;
      while (!is_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      check("ready_before_issue", is_ready, 1'b1);
      is_input_valid = 1'b1;
      addr = a;
      mem_write = wr;
      mem_read = !wr;
      din = d;
      @(negedge clk);
      is_input_valid = 1'b0;
      mem_write = 1'b0;
      mem_read = 1'b0;
      addr = 32'hFFFF_FFFC;
      din = 32'hBAD0_BAD0;
   endtask

   task automatic wait_done(output logic [31:0] rd, output logic hit, output int lat);
      lat = 1;
      while (!is_output_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      check("completion_seen", is_output_valid, 1'b1);
      rd = dout;
      hit = is_hit;
      @(negedge clk);
   endtask

   task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic hit);
      int lat;
      issue(wr, a, d);
      wait_done(rd, hit, lat);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0]          rd;
      logic                 hit;
      int                   lat;
      int                   w0, r0, b0, guard;
      logic                 stable, quiet;
      logic [31:0]          a0;
      logic [LINE_BITS-1:0] d0;

      reset = 1'b1;
      is_input_valid = 1'b0;
      addr = '0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      din = '0;
      @(negedge clk);
      check("rst_is_ready", is_ready, 1'b0);
      check("rst_out_valid", is_output_valid, 1'b0);
      check("rst_is_hit", is_hit, 1'b0);
      check("rst_dout", dout, 32'h0);
      check("rst_m_valid", m_is_input_valid, 1'b0);
      check("rst_m_rw", {m_read, m_write}, 2'b00);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_m_din_lo", m_din[63:0], 64'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", is_ready, 1'b1);

      // Cold load, then the same load as a one-cycle hit with no memory traffic
      r0 = n_mread;
      access(1'b0, 32'h0000_0104, 32'h0, rd, hit);
      check("cold_dout", rd, 32'hDEAD_BEEF);
      check("cold_is_hit", hit, 1'b0);
      check("cold_one_refill", n_mread - r0, 1);
      check("cold_refill_addr", last_rd_addr, 32'h0000_0100);
      check("cold_no_write", n_mwrite, 0);

      b0 = m_busy;
      issue(1'b0, 32'h0000_0104, 32'h0);
      check("hit_lat1_valid", is_output_valid, 1'b1);
      check("hit_dout", dout, 32'hDEAD_BEEF);
      check("hit_is_hit", is_hit, 1'b1);
      check("hit_not_ready", is_ready, 1'b0);
      @(negedge clk);
      check("hit_single_pulse", is_output_valid, 1'b0);
      check("hit_ready_again", is_ready, 1'b1);
      check("hit_no_mem_activity", m_busy - b0, 0);

      // Store hit stays in the cache
      access(1'b1, 32'h0000_0108, 32'h1234_5678, rd, hit);
      check("store_is_hit", hit, 1'b1);
      access(1'b0, 32'h0000_0108, 32'h0, rd, hit);
      check("store_readback", rd, 32'h1234_5678);
      check("store_readback_hit", hit, 1'b1);
      check("store_no_mem_activity", m_busy - b0, 0);

      // LRU: 0x200 becomes LRU after touching 0x100, so 0x300 evicts it cleanly
      access(1'b0, 32'h0000_0100, 32'h0, rd, hit);
      check("lru_100_hit", hit, 1'b1);
      check("lru_100_dout", rd, 32'hA500_0100);
      access(1'b0, 32'h0000_0200, 32'h0, rd, hit);
      check("lru_200_miss", hit, 1'b0);
      check("lru_200_dout", rd, 32'hA500_0200);
      access(1'b0, 32'h0000_0100, 32'h0, rd, hit);
      check("lru_100_rehit", hit, 1'b1);
      access(1'b0, 32'h0000_0300, 32'h0, rd, hit);
      check("lru_300_miss", hit, 1'b0);
      check("lru_300_dout", rd, 32'hA500_0300);
      check("lru_no_writeback", n_mwrite, 0);
      access(1'b0, 32'h0000_0100, 32'h0, rd, hit);
      check("lru_100_survives", hit, 1'b1);
      access(1'b0, 32'h0000_0200, 32'h0, rd, hit);
      check("lru_200_was_evicted", hit, 1'b0);

      // Dirty eviction with a stalled writeback
      do_reset();
      w0 = n_mwrite;
      access(1'b1, 32'h0000_0200, 32'hAAAA_0001, rd, hit);
      check("dirty_store_miss", hit, 1'b0);
      access(1'b0, 32'h0000_0300, 32'h0, rd, hit);
      check("dirty_300_no_wb", n_mwrite - w0, 0);
      stall_cycles = 10;
      issue(1'b0, 32'h0000_0400, 32'h0);
      guard = 0;
      while (!m_write && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("wb_started", m_write, 1'b1);
      check("wb_addr", m_addr, 32'h0000_0200);
      check("wb_din_word0", m_din[31:0], 32'hAAAA_0001);
      a0 = m_addr;
      d0 = m_din;
      stable = 1'b1;
      quiet = 1'b1;
      repeat (9) begin
         @(negedge clk);
         if (m_addr !== a0 || m_din !== d0 || m_write !== 1'b1 || m_is_input_valid !== 1'b1) stable = 1'b0;
         if (is_ready !== 1'b0 || is_output_valid !== 1'b0) quiet = 1'b0;
      end
      check("stall_request_stable", stable, 1'b1);
      check("stall_cpu_quiet", quiet, 1'b1);
      wait_done(rd, hit, lat);
      stall_cycles = 0;
      check("dirty_400_dout", rd, 32'hA500_0400);
      check("dirty_400_miss", hit, 1'b0);
      check("dirty_one_write", n_mwrite - w0, 1);
      check("dirty_write_addr", last_wr_addr, 32'h0000_0200);
      check("dirty_write_first", last_wr_seq < last_rd_seq, 1'b1);
      check("dirty_read_addr", last_rd_addr, 32'h0000_0400);
      access(1'b0, 32'h0000_0200, 32'h0, rd, hit);
      check("wb_data_in_memory", rd, 32'hAAAA_0001);

      // Reset while the refill is outstanding
      r0 = n_mread;
      issue(1'b0, 32'h0000_0500, 32'h0);
      guard = 0;
      while (n_mread == r0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("midrst_read_issued", n_mread - r0, 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_no_pulse", is_output_valid, 1'b0);
      check("midrst_m_quiet", m_is_input_valid, 1'b0);
      reset = 1'b0;
      quiet = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (is_output_valid !== 1'b0) quiet = 1'b0;
      end
      check("midrst_no_completion", quiet, 1'b1);
      access(1'b0, 32'h0000_0500, 32'h0, rd, hit);
      check("midrst_line_not_installed", hit, 1'b0);
      check("midrst_reload_dout", rd, 32'hA500_0500);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
